// File: rtl/spi_slave.sv
// spi_slave: single-clock SPI slave shift engine clocked by the master's sclk.
//
// Ports:
//   sclk     in   1           SPI serial clock; all logic on its rising edge
//   rst      in   1           synchronous active-high reset
//   mosi     in   1           serial data from master
//   miso     out  1           serial data to master (registered)
//   data_in  in   DATA_WIDTH  transmit word, captured while load=1
//   load     in   1           arm a new frame and capture data_in
//   data_out out  DATA_WIDTH  last complete received word
//   done     out  1           one-cycle pulse when a frame completes
//
// Build option: define SPI_SLAVE_LSB_FIRST_EN for LSB-first framing on both
// lines; the default build is MSB first.
module spi_slave #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  load,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  done
);
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, ARM, SHIFT} state_t;

    state_t                state, state_n;
    // The bit currently on miso lives in the miso register itself, so tx only
    // holds the DATA_WIDTH-1 bits still waiting to go out. Likewise the final
    // received bit is taken straight from mosi, so rx holds DATA_WIDTH-1 bits.
    logic [DATA_WIDTH-2:0] tx, tx_n, rx, rx_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic                  miso_n, done_n;
    logic [DATA_WIDTH-1:0] data_out_n;

    logic [DATA_WIDTH-1:0] rx_word, tx_word;
    logic [DATA_WIDTH-2:0] rx_shift, tx_shift, load_rest;
    logic                  tx_bit, load_bit;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign rx_word   = {mosi, rx};
    assign rx_shift  = rx_word[DATA_WIDTH-1:1];
    assign tx_word   = {1'b0, tx};
    assign tx_shift  = tx_word[DATA_WIDTH-1:1];
    assign tx_bit    = tx_word[0];
    assign load_bit  = data_in[0];
    assign load_rest = data_in[DATA_WIDTH-1:1];
`else
    assign rx_word   = {rx, mosi};
    assign rx_shift  = rx_word[DATA_WIDTH-2:0];
    assign tx_word   = {tx, 1'b0};
    assign tx_shift  = tx_word[DATA_WIDTH-2:0];
    assign tx_bit    = tx_word[DATA_WIDTH-1];
    assign load_bit  = data_in[DATA_WIDTH-1];
    assign load_rest = data_in[DATA_WIDTH-2:0];
`endif

    always_ff @(posedge sclk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= '0;
            rx       <= '0;
            cnt      <= '0;
            miso     <= 1'b0;
            done     <= 1'b0;
            data_out <= '0;
        end else begin
            state    <= state_n;
            tx       <= tx_n;
            rx       <= rx_n;
            cnt      <= cnt_n;
            miso     <= miso_n;
            done     <= done_n;
            data_out <= data_out_n;
        end
    end

    always_comb begin
        state_n    = state;
        tx_n       = tx;
        rx_n       = rx;
        cnt_n      = cnt;
        miso_n     = miso;
        done_n     = 1'b0;
        data_out_n = data_out;
        // load wins in every state: arms from IDLE, recaptures in ARM and
        // aborts a frame in progress, dropping the partial rx word.
        if (load) begin
            state_n = ARM;
            tx_n    = load_rest;
            rx_n    = '0;
            cnt_n   = '0;
            miso_n  = load_bit;
        end else begin
            case (state)
                IDLE: miso_n = 1'b0;
                ARM: state_n = SHIFT;
                SHIFT: begin
                    rx_n   = rx_shift;
                    tx_n   = tx_shift;
                    miso_n = tx_bit;
                    cnt_n  = cnt + CW'(1);
                    if (cnt == CW'(DATA_WIDTH - 1)) begin
                        data_out_n = rx_word;
                        done_n     = 1'b1;
                        miso_n     = 1'b0;
                        state_n    = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                    miso_n  = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed self-checking bench for spi_slave (8-bit frames).
module tb_spi_slave;
    logic       sclk = 1'b0;
    logic       rst, mosi, load, miso, done;
    logic [7:0] data_in, data_out;

    int  n_assert = 0;
    int  n_fail   = 0;
    int  done_cnt = 0;
    int  c0;
    time t_prev   = 0;
    time t_last   = 0;

    always #5 sclk = ~sclk;

    spi_slave #(.DATA_WIDTH(8)) dut (
        .sclk(sclk), .rst(rst), .mosi(mosi), .miso(miso),
        .data_in(data_in), .load(load), .data_out(data_out), .done(done)
    );

    always @(posedge sclk) begin
        #1;
        if (done === 1'b1) begin
            done_cnt++;
            t_prev = t_last;
            t_last = $time;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bit_idx(input int i);
`ifdef SPI_SLAVE_LSB_FIRST_EN
        return i;
`else
        return 7 - i;
`endif
    endfunction

    // Called just after a falling edge; returns at the falling edge of the done cycle.
    task automatic frame(input logic [7:0] din, input logic [7:0] mo, input string tag);
        logic [7:0] got;
        got = '0;
        data_in = din;
        load = 1'b1;
        @(negedge sclk);
        load = 1'b0;
        @(negedge sclk);
        for (int i = 0; i < 8; i++) begin
            got[bit_idx(i)] = miso;
            mosi = mo[bit_idx(i)];
            @(negedge sclk);
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_data_out"}, data_out, mo);
        chk({tag, "_miso_bits"}, got, din);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; mosi = 1'b0; data_in = '0;
        repeat (3) @(negedge sclk);
        chk("reset_miso", miso, 0);
        chk("reset_done", done, 0);
        chk("reset_data_out", data_out, 0);
        rst = 1'b0;
        @(negedge sclk);

        c0 = done_cnt;
        frame(8'b10101010, 8'b11001100, "basic");
        @(negedge sclk);
        chk("basic_done_pulse_width", done, 0);
        chk("basic_done_count", done_cnt, c0 + 1);
        chk("basic_idle_miso", miso, 0);

        c0 = done_cnt;
        data_in = 8'h12;
        load = 1'b1;
        @(negedge sclk);
        load = 1'b0;
        @(negedge sclk);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            @(negedge sclk);
        end
        chk("abort_hold_data_out", data_out, 8'hCC);
        frame(8'hF0, 8'h5A, "abort");
        chk("abort_done_count", done_cnt, c0 + 1);

        c0 = done_cnt;
        frame(8'h55, 8'h3C, "b2b_first");
        frame(8'hA5, 8'hC3, "b2b_second");
        chk("b2b_done_count", done_cnt, c0 + 2);
        chk("b2b_done_spacing", 32'(t_last - t_prev), 100);

        @(negedge sclk);
        c0 = done_cnt;
        for (int i = 0; i < 20; i++) begin
            mosi = ~mosi;
            @(negedge sclk);
            chk("idle_miso", miso, 0);
        end
        chk("idle_done_count", done_cnt, c0);
        chk("idle_data_out", data_out, 8'hC3);

        c0 = done_cnt;
        data_in = 8'hFF;
        load = 1'b1;
        @(negedge sclk);
        load = 1'b0;
        @(negedge sclk);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            @(negedge sclk);
        end
        chk("midframe_miso_before_reset", miso, 1);
        rst = 1'b1;
        load = 1'b1;
        @(negedge sclk);
        chk("midreset_miso", miso, 0);
        chk("midreset_done", done, 0);
        chk("midreset_data_out", data_out, 0);
        rst = 1'b0;
        load = 1'b0;
        @(negedge sclk);
        chk("reset_overrides_load_miso", miso, 0);
        @(negedge sclk);
        chk("reset_overrides_load_miso2", miso, 0);
        chk("midreset_done_count", done_cnt, c0);

        frame(8'h0F, 8'h96, "post_reset");
        chk("post_reset_done_count", done_cnt, c0 + 1);
`ifdef SPI_SLAVE_LSB_FIRST_EN
        @(negedge sclk);
        frame(8'h01, 8'h81, "lsb_first");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
